regfile_dump_streamer: RTL and testbench
========================================

// Module: regfile_dump_streamer
// PURPOSE
//  Post-run register-file readout engine; the hardware counterpart of the bench test-harness read-hijack.
//  On start, takes over the regfile read-A select, scans r0..r(NUM_REGS-1) and streams
//  {index,data} beats out on a valid/ready interface for a logger, UART or checker.
//  Sits between processor ctrl_readRegA and regfile ctrl_readRegA; transparent when idle.
// PARAMETERS
//  NUM_REGS  32  registers scanned, indices 0..NUM_REGS-1 (2..32)
//  IDX_W     5   register index width
//  DATA_W    32  register data width
// PORTS
//  clock      in   1       system clock, all state updates on rising edge
//  reset      in   1       synchronous, active-high
//  start      in   1       request a dump; sampled only in IDLE
//  cpu_rs1    in   IDX_W   processor ctrl_readRegA
//  rs1_out    out  IDX_W   to regfile ctrl_readRegA
//  reg_data   in   DATA_W  regfile data_readRegA (combinational read)
//  out_valid  out  1       beat valid
//  out_ready  in   1       sink accepts beat
//  out_index  out  IDX_W   register index of beat
//  out_data   out  DATA_W  register value of beat
//  out_last   out  1       final beat of dump
//  busy       out  1       dump in progress (state != IDLE)
//  done       out  1       one-cycle pulse after final handshake
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, out_valid=0, out_index=0, out_data=0, out_last=0, busy=0, done=0.
//  - rs1_out = busy ? idx : cpu_rs1 (combinational mux).
//  - FSM IDLE -> LOAD -> SEND -> (LOAD | DONE) -> IDLE.
//  - IDLE: start=1 at edge -> LOAD, idx=0.
//  - LOAD: rs1_out=idx; next edge registers out_data=reg_data, out_index=idx, out_valid=1,
//    out_last=(idx==NUM_REGS-1, or 0 with DUMP_CHECKSUM_EN); -> SEND.
//  - SEND: out_valid && out_ready at edge = handshake; out_valid<=0.
//    No handshake: out_* held bit-stable.
//    Handshake with out_last=1 -> DONE; otherwise idx<=idx+1 -> LOAD.
//  - DONE: done=1 for exactly that cycle -> IDLE.
//  - Throughput: 2 cycles/beat with out_ready held 1. 32 regs: 64 cycles start-sample to final
//    handshake; done on the next cycle.
//  - start while busy: ignored. start held high: a new dump begins only after return to IDLE.
//  - out_ready asserted with out_valid=0: no effect.
//  - Reset mid-dump: all outputs take reset values on that edge.
//    rs1_out reverts to cpu_rs1 in the following cycle. No partial beat or done is emitted.
//  - idx never wraps: the maximum is NUM_REGS-1.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined:
//    - Running sum, DATA_W-bit wrapping: cleared on start, accumulates out_data at each register handshake.
//    - After register NUM_REGS-1 is accepted, -> SUM state: one extra beat, out_index=0,
//      out_data=sum, out_last=1, same valid/ready rules; its handshake -> DONE.
//    - Register beats have out_last=0. Dump = NUM_REGS+1 beats.
//  Not defined: no sum logic; out_last on register NUM_REGS-1; dump = NUM_REGS beats.
// TESTING
//  1 Idle passthrough: cpu_rs1=7, no start -> rs1_out=7, busy=0, out_valid=0.
//  2 Full dump: preload r_i=i*16+1 (r0=0 per regfile), pulse start, out_ready=1 -> 32 beats,
//    index 0..31, data 0,17,..,497. out_last only on idx 31. done 1 cycle after, lasting 1 cycle.
//  3 Backpressure: out_ready=0 for 5 cycles while beat idx 3 is valid
//    -> out_index=3, out_data=49 stable throughout; idx 4 follows 1 cycle after ready rises.
//  4 start re-pulsed at beat 10 -> ignored. Exactly 32 beats. Single done.
//  5 reset asserted at beat 10 -> next cycle out_valid=0, busy=0, rs1_out=cpu_rs1.
//    Fresh start -> beats restart at idx 0.
//  6 DUMP_CHECKSUM_EN, r_i=i -> 33 beats. Beat 33: out_index=0, out_data=496, out_last=1.

Source files
------------

// File: rtl/regfile_dump_streamer.sv
// Register-file dump streamer: hijacks the regfile read-A select and streams {index,data} beats.
// Optional DUMP_CHECKSUM_EN appends a final beat carrying the wrapping sum of all register values.
module regfile_dump_streamer #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  cpu_rs1,
  output logic [IDX_W-1:0]  rs1_out,
  input  logic [DATA_W-1:0] reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_SUM,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              vld_q, vld_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              hs;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign hs = vld_q && out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    index_d = index_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef DUMP_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
`ifdef DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      // Regfile read is combinational: capture it while rs1_out points at idx.
      S_LOAD: begin
        data_d  = reg_data;
        index_d = idx_q;
        vld_d   = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        last_d  = 1'b0;
`else
        last_d  = (idx_q == LAST_IDX);
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
          vld_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
          if (!last_q) begin
            sum_d = sum_q + data_q;
          end
          if (last_q) begin
            state_d = S_DONE;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_SUM;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
`else
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      // Checksum beat is presented like a register beat, then handled by S_SEND.
      S_SUM: begin
        data_d  = sum_q;
        index_d = '0;
        vld_d   = 1'b1;
        last_d  = 1'b1;
        state_d = S_SEND;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      index_q <= index_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rs1_out   = busy ? idx_q : cpu_rs1;
  assign out_valid = vld_q;
  assign out_index = index_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Randomized bench for regfile_dump_streamer: a behavioural regfile plus an expected-beat queue
// built from the register contents at start time; honours DUMP_CHECKSUM_EN for the extra sum beat.
module tb_regfile_dump_streamer;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [IDX_W-1:0]  cpu_rs1;
  logic [IDX_W-1:0]  rs1_out;
  logic [DATA_W-1:0] reg_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_index;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [NUM_REGS];
  int                cyc = 0;
  int                vectors = 0;
  int                miscompares = 0;

  regfile_dump_streamer #(
    .NUM_REGS(NUM_REGS),
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .cpu_rs1  (cpu_rs1),
    .rs1_out  (rs1_out),
    .reg_data (reg_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // r0 reads as zero, like the processor regfile
  assign reg_data = (rs1_out == '0) ? '0 : regs[rs1_out];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One complete dump with random (or stalled) backpressure; caller is at a negedge, DUT idle.
  task automatic run_dump(input int pct, input int stall_idx, input int stall_len,
                          input int repulse_beat);
    beat_t             q[$];
    beat_t             hd;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] d;
    int                total, beats, done_cnt, post, start_cyc, last_hs, stall_left;
    bit                prev_pend, repulsed;
    logic [IDX_W-1:0]  p_idx;
    logic [DATA_W-1:0] p_data;
    logic              p_last;

    sum = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      d = (i == 0) ? '0 : regs[i];
      sum = sum + d;
`ifdef DUMP_CHECKSUM_EN
      q.push_back('{IDX_W'(i), d, 1'b0});
`else
      q.push_back('{IDX_W'(i), d, (i == NUM_REGS - 1)});
`endif
    end
`ifdef DUMP_CHECKSUM_EN
    q.push_back('{'0, sum, 1'b1});
`endif
    total = q.size();
    beats = 0; done_cnt = 0; post = 0; last_hs = -100;
    stall_left = stall_len; prev_pend = 0; repulsed = 0;
    p_idx = '0; p_data = '0; p_last = 1'b0;

    start     = 1'b1;
    start_cyc = cyc + 1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (!busy) chk("passthru_rs1", 64'(rs1_out), 64'(cpu_rs1));
      if (prev_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_index", 64'(out_index), 64'(p_idx));
        chk("hold_data",  64'(out_data),  64'(p_data));
        chk("hold_last",  64'(out_last),  64'(p_last));
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_hs", 64'(cyc), 64'(last_hs));
      end
      if (done_cnt > 0) begin
        if (post > 0) chk("idle_after_done", 64'(busy), 64'd0);
        if (post >= 3) break;
        post++;
      end

      if (out_valid && out_index == IDX_W'(stall_idx) && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) < pct);
      end
      start = 1'b0;
      if (!repulsed && beats == repulse_beat && busy) begin
        start    = 1'b1;
        repulsed = 1;
      end
      cpu_rs1 = IDX_W'($urandom);

      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          hd = q.pop_front();
          chk("beat_index", 64'(out_index), 64'(hd.idx));
          chk("beat_data",  64'(out_data),  64'(hd.data));
          chk("beat_last",  64'(out_last),  64'(hd.last));
        end
        beats++;
        last_hs = cyc + 1;
      end
      prev_pend = out_valid && !out_ready;
      p_idx = out_index; p_data = out_data; p_last = out_last;
    end
    start = 1'b0;
    chk("beat_count", 64'(beats), 64'(total));
    chk("done_count", 64'(done_cnt), 64'd1);
    if (pct == 100)
      chk("dump_latency", 64'(last_hs - start_cyc), 64'(2 * total + stall_len));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; cpu_rs1 = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(i * 16 + 1);
    repeat (3) @(negedge clock);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    reset = 1'b0;

    // idle passthrough, ready toggling with no valid must do nothing
    cpu_rs1 = 5'd7; out_ready = 1'b1;
    @(negedge clock);
    chk("idle_rs1",   64'(rs1_out),   64'd7);
    chk("idle_busy",  64'(busy),      64'd0);
    chk("idle_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cpu_rs1 = IDX_W'($urandom);
      @(negedge clock);
      chk("idle_rs1_rand", 64'(rs1_out), 64'(cpu_rs1));
      chk("idle_no_valid", 64'(out_valid), 64'd0);
    end

    // full dump at full rate, then backpressure on beat 3, then ignored re-start at beat 10
    run_dump(100, -1, 0, -1);
    run_dump(100, 3, 5, -1);
    run_dump(100, -1, 0, 10);

    // reset in the middle of a dump
    out_ready = 1'b1;
    start = 1'b1;
    begin
      int hs_seen;
      hs_seen = 0;
      for (int n = 0; n < 200 && hs_seen < 10; n++) begin
        @(negedge clock);
        start = 1'b0;
        if (out_valid && out_ready) hs_seen++;
      end
      chk("pre_reset_beats", 64'(hs_seen), 64'd10);
    end
    reset = 1'b1;
    cpu_rs1 = 5'd19;
    @(negedge clock);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy",  64'(busy),      64'd0);
    chk("midrst_done",  64'(done),      64'd0);
    chk("midrst_rs1",   64'(rs1_out),   64'd19);
    chk("midrst_last",  64'(out_last),  64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("postrst_valid", 64'(out_valid), 64'd0);
    run_dump(100, -1, 0, -1);

`ifdef DUMP_CHECKSUM_EN
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(i);
    run_dump(100, -1, 0, -1);
`endif

    // random contents and random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'($urandom);
      run_dump(30 + 20 * r, -1, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
